// File: rtl/stm_pkg.sv
// Shared definitions for the two-phase state machine and its downstream pair collector.
// The phase encoding is common to the upstream machine and this collector, so both
// agree on which cycle carries the A result and which carries the B result.
package stm_pkg;

    // Default width of one word on the upstream `outputs` bus.
    localparam int unsigned DwDefault = 32;

    // One pair is {B word, A word}.
    localparam int unsigned PairWDefault = 2 * DwDefault;

    // WARM: the first cycle after reset, when the bus still holds the upstream
    //       register's initial value.
    // CAP_A / CAP_B: the cycles that carry the A and B results.
    typedef enum logic [1:0] {
        StWarm = 2'b00,
        StCapA = 2'b01,
        StCapB = 2'b10
    } phase_e;

endpackage

// File: rtl/stm_pair_fifo.sv
// Show-ahead FIFO that holds {B word, A word} pairs.
//   CLK        clock, rising edge
//   RST        synchronous reset, active-high; clears pointers and level
//   push       write push_data this cycle (refused when full, unless a pop happens too)
//   push_data  pair to store
//   pop        remove the head this cycle (ignored when empty)
//   head       registered storage at the read pointer
//   level      occupancy, 0..DEPTH
module stm_pair_fifo
    import stm_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = PairWDefault
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] Full = LvlW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;

    logic do_pop;
    logic do_push;

    // A pop frees the slot the same cycle, so a push onto a full FIFO still lands.
    assign do_pop  = pop && (level_q != '0);
    assign do_push = push && ((level_q != Full) || do_pop);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        // Level is tracked apart from the pointers, so full and empty never alias.
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: it is only visible while level is non-zero.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rptr_q];
    assign level = level_q;

endmodule

// File: rtl/stm_pair_collector.sv
// Pairs the A-phase and B-phase words of the upstream two-phase machine's output bus
// and queues each pair for the next stage. Upstream cannot be stalled, so pairs that
// find the queue full are dropped and counted.
//   CLK         clock, rising edge
//   RST         synchronous reset, active-high; discards queue, half-formed pair and count
//   in_data     upstream `outputs` bus, sampled every cycle
//   out_valid   head of the queue holds a pair
//   out_ready   consumer takes the head this cycle
//   out_data    queue head, {B word, A word}
//   level       queue occupancy
//   drop_count  pairs lost to overflow, saturating
module stm_pair_collector
    import stm_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = DwDefault,
    parameter int unsigned CNTW  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DW-1:0]          in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*DW-1:0]        out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNTW-1:0]        drop_count
);

    localparam int unsigned LvlW = $clog2(DEPTH) + 1;
    localparam logic [LvlW-1:0] Full = LvlW'(DEPTH);

    phase_e          state_q, state_d;
    logic [DW-1:0]   a_hold_q, a_hold_d;
    logic [CNTW-1:0] drop_q, drop_d;

    logic            push;
    logic            pop;
    logic            drop;
    logic [LvlW-1:0] fifo_level;

    always_comb begin
        state_d  = state_q;
        a_hold_d = a_hold_q;
        push     = 1'b0;
        unique case (state_q)
            StWarm: begin
                state_d = StCapA;
            end
            StCapA: begin
                a_hold_d = in_data;
                state_d  = StCapB;
            end
            StCapB: begin
                push    = 1'b1;
                state_d = StCapA;
            end
            default: begin
                state_d = StWarm;
            end
        endcase
    end

    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;
    // Mirrors the FIFO's acceptance rule: only a full FIFO without a pop refuses.
    assign drop      = push && (fifo_level == Full) && !pop;

    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StWarm;
            a_hold_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_hold_q <= a_hold_d;
            drop_q   <= drop_d;
        end
    end

    stm_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DW)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data ({in_data, a_hold_q}),
        .pop       (pop),
        .head      (out_data),
        .level     (fifo_level)
    );

    assign level      = fifo_level;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_stm_pair_collector.sv
module tb_stm_pair_collector;

    localparam int unsigned Depth = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        out_valid, out_valid_s;
    logic [63:0] out_data, out_data_s;
    logic [2:0]  level, level_s;
    logic [15:0] drop_count;
    logic [3:0]  drop_count_s;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    stm_pair_collector #(.DEPTH(4), .DW(32), .CNTW(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .drop_count (drop_count)
    );

    // Same stimulus, narrow counter, to see saturation.
    stm_pair_collector #(.DEPTH(4), .DW(32), .CNTW(4)) dut_sat (
        .CLK        (CLK),
        .RST        (RST),
        .in_data    (in_data),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready),
        .out_data   (out_data_s),
        .level      (level_s),
        .drop_count (drop_count_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: k counts edges since reset; k=0 is the warm-up edge,
    // odd k captures A, even k>0 forms a pair.
    logic [63:0] mq[$];
    logic [31:0] m_a;
    int          m_k = 0;
    int          m_drop16 = 0;
    int          m_drop4 = 0;
    bit          m_live = 0;

    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            m_k      = 0;
            m_drop16 = 0;
            m_drop4  = 0;
            m_live   = 1;
        end else if (m_live) begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (m_k > 0 && (m_k % 2) == 1) begin
                m_a = in_data;
            end else if (m_k > 0) begin
                if (mq.size() < Depth) mq.push_back({in_data, m_a});
                else begin
                    if (m_drop16 < 65535) m_drop16++;
                    if (m_drop4 < 15) m_drop4++;
                end
            end
            m_k++;
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            chk("m_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
            chk("m_level", {61'd0, level}, 64'(mq.size()));
            chk("m_drop", {48'd0, drop_count}, 64'(m_drop16));
            chk("m_drop_sat", {60'd0, drop_count_s}, 64'(m_drop4));
            if (mq.size() != 0) chk("m_data", out_data, mq[0]);
        end
    end

    // Apply inputs just after an edge, then wait for the next edge to take them.
    task automatic step(input logic rst, input logic [31:0] d, input logic rdy);
        RST       = rst;
        in_data   = d;
        out_ready = rdy;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        @(posedge CLK);
        #1;

        // Basic pair
        step(1'b1, 32'h0, 1'b1);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_level", {61'd0, level}, 64'd0);
        chk("rst_drop", {48'd0, drop_count}, 64'd0);
        step(1'b0, 32'hDEADBEEF, 1'b1);
        step(1'b0, 32'h11111111, 1'b1);
        chk("basic_nvalid", {63'd0, out_valid}, 64'd0);
        step(1'b0, 32'h22222222, 1'b1);
        chk("basic_valid", {63'd0, out_valid}, 64'd1);
        chk("basic_data", out_data, 64'h22222222_11111111);
        step(1'b0, 32'h0, 1'b1);
        chk("basic_drain", {61'd0, level}, 64'd0);

        // Stream
        step(1'b1, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 32'(i), 1'b1);
            if ((i % 2) == 0) begin
                chk("stream_valid", {63'd0, out_valid}, 64'd1);
                chk("stream_data", out_data, {32'(i), 32'(i - 1)});
            end else begin
                chk("stream_gap", {63'd0, out_valid}, 64'd0);
            end
        end
        chk("stream_drop", {48'd0, drop_count}, 64'd0);

        // Overflow: five pairs into four slots
        step(1'b1, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 10; i++) step(1'b0, 32'h100 + 32'(i), 1'b0);
        chk("ovf_level", {61'd0, level}, 64'd4);
        chk("ovf_drop", {48'd0, drop_count}, 64'd1);
        chk("ovf_head", out_data, 64'h00000102_00000101);

        // Full plus pop on a CAP_B cycle
        step(1'b0, 32'h201, 1'b0);
        step(1'b0, 32'h202, 1'b1);
        chk("fp_level", {61'd0, level}, 64'd4);
        chk("fp_drop", {48'd0, drop_count}, 64'd1);
        chk("fp_head", out_data, 64'h00000104_00000103);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("fp_new_last", out_data, 64'h00000202_00000201);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        // Reset mid-pair on a CAP_A cycle with two entries queued
        step(1'b1, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b0, 32'h300 + 32'(i), 1'b0);
        chk("mid_two", {61'd0, level}, 64'd2);
        step(1'b1, 32'h305, 1'b0);
        chk("mid_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_level", {61'd0, level}, 64'd0);
        chk("mid_drop", {48'd0, drop_count}, 64'd0);
        step(1'b0, 32'h999, 1'b1);
        step(1'b0, 32'h401, 1'b1);
        step(1'b0, 32'h402, 1'b1);
        chk("mid_pair", out_data, 64'h00000402_00000401);

        // Saturation: 20 pairs, 4 kept, 16 dropped
        step(1'b1, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 40; i++) step(1'b0, 32'h500 + 32'(i), 1'b0);
        chk("sat_narrow", {60'd0, drop_count_s}, 64'hF);
        chk("sat_wide", {48'd0, drop_count}, 64'd16);
        chk("sat_head", out_data_s, 64'h00000502_00000501);
        step(1'b1, 32'h0, 1'b0);
        chk("sat_clear", {60'd0, drop_count_s}, 64'd0);

        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
